program_counter_ras: RTL and testbench
======================================

Name: program_counter_ras

Overview:
- N-bit program counter with sequential increment, absolute load, PC-relative branch, and call/return through a DEPTH-entry hardware return-address stack (RAS).
- Next-generation PC for the datapath. Adds a configurable step, a stall input, signed branch offsets, nested subroutine support and sticky stack-error flags.
- Feeds the instruction-memory address. Driven by the control unit.

Parameters:
- N, 32, PC / address width in bits.
- DEPTH, 8, number of return-address stack entries (≥2).
- STEP, 1, increment amount per sequential advance.
- RST_VEC, 0, pc_out value after reset.
- TRAP_VEC, 'hFFFF_FFF0 (truncated to N), error target PC; used only with PC_TRAP_EN.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_stall  in  1  freeze all state this cycle.
- pc_load  in  1  absolute load: pc_out <= pc_data.
- pc_data  in  N  load / call target.
- pc_branch  in  1  relative branch: pc_out <= pc_out + pc_offset.
- pc_offset  in  N  two's-complement branch offset.
- pc_call  in  1  push pc_out+STEP onto the RAS; pc_out <= pc_data.
- pc_ret  in  1  pop the RAS; pc_out <= popped value.
- pc_inc  in  1  pc_out <= pc_out + STEP.
- err_clr  in  1  clear the sticky error flags.
- pc_out  out  N  current PC (registered).
- sp_level  out  $clog2(DEPTH+1)  number of valid RAS entries.
- stack_full  out  1  sp_level == DEPTH (combinational from sp).
- stack_empty  out  1  sp_level == 0 (combinational from sp).
- stack_ovf  out  1  sticky: a call was attempted while full.
- stack_unf  out  1  sticky: a return was attempted while empty.

Behaviour:
- Reset (async, rst_n=0):
  - pc_out=RST_VEC, sp_level=0, all RAS entries=0, stack_ovf=0, stack_unf=0.
  - Deassertion takes effect at the next rising clk edge.
- Command priority per cycle, highest first: pc_stall > pc_load > pc_call > pc_ret > pc_branch > pc_inc > hold.
  - Only the winning command acts; lower-priority commands are ignored that cycle.
- pc_stall=1: pc_out, RAS and sp_level hold; flags hold. err_clr is still honoured.
- Latency: one cycle. The new pc_out is visible after the rising edge at which the command is sampled.
- Arithmetic:
  - All sums are modulo 2^N; no carry out and no saturation.
  - Example: pc_out=2^N−1 with pc_inc and STEP=1 gives 0.
  - Branch: pc_out + pc_offset, where pc_offset is two's complement.
- Call, not full:
  - RAS[sp] <= pc_out+STEP, sp <= sp+1, pc_out <= pc_data.
- Call while full:
  - No push, sp unchanged, pc_out holds, stack_ovf <= 1.
- Return, not empty:
  - pc_out <= RAS[sp−1], sp <= sp−1.
- Return while empty:
  - pc_out holds, stack_unf <= 1.
- Stack is LIFO. Entries above sp are don't-care and are not cleared on pop.
- err_clr=1 clears both sticky flags. If a new error occurs in the same cycle, set wins (flag ends at 1).
- Reset mid-sequence: the stack is discarded (sp=0) and pc_out=RST_VEC immediately, without waiting for clk.

Optional Feature:
- Macro: PC_TRAP_EN.
- Defined: a call while full or a return while empty additionally loads pc_out <= TRAP_VEC in that cycle. sp is unchanged and the flag is set as above.
- Undefined: on these errors pc_out holds, as specified in Behaviour. The TRAP_VEC parameter is unused.

Test Plan:
- Reset/inc: N=32, STEP=1. Release reset, pc_inc for 5 cycles → pc_out 0,1,2,3,4,5. Assert rst_n=0 mid-cycle → pc_out=0 with no clk edge.
- Load/branch/wrap:
  - load 0x100 → 0x100.
  - Branch offset 0xFFFF_FFF0 (−16) → 0xF0.
  - load 0xFFFF_FFFF then inc → 0x0000_0000.
- Nested call/return:
  - At pc 0x10, call 0x200 → pc 0x200, sp_level=1.
  - Call 0x300 → pc 0x300, sp_level=2.
  - ret → 0x201; ret → 0x11; stack_empty=1.
- Overflow/underflow (DEPTH=8):
  - 8 calls reach stack_full=1. A 9th call leaves pc held and sets stack_ovf=1.
  - 8 rets reach empty. A 9th ret sets stack_unf=1.
  - err_clr → both flags 0.
  - With PC_TRAP_EN defined, the 9th call gives pc_out=TRAP_VEC.
- Priority/stall:
  - pc_load+pc_call+pc_inc asserted together with pc_data=0x40 → pc_out=0x40, sp unchanged.
  - pc_stall with pc_call asserted → no change to pc_out or sp_level.
- Simultaneous clear/set: stack empty, ret together with err_clr → stack_unf=1.

Source files
------------

// File: rtl/program_counter_ras_if.sv
// Command/status bundle between the control unit (master) and program_counter_ras (slave).
interface program_counter_ras_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned SPW = $clog2(DEPTH + 1);

  logic           pc_stall;
  logic           pc_load;
  logic [N-1:0]   pc_data;
  logic           pc_branch;
  logic [N-1:0]   pc_offset;
  logic           pc_call;
  logic           pc_ret;
  logic           pc_inc;
  logic           err_clr;
  logic [N-1:0]   pc_out;
  logic [SPW-1:0] sp_level;
  logic           stack_full;
  logic           stack_empty;
  logic           stack_ovf;
  logic           stack_unf;

  modport master (
    output pc_stall, pc_load, pc_data, pc_branch, pc_offset,
           pc_call, pc_ret, pc_inc, err_clr,
    input  pc_out, sp_level, stack_full, stack_empty, stack_ovf, stack_unf
  );

  modport slave (
    input  pc_stall, pc_load, pc_data, pc_branch, pc_offset,
           pc_call, pc_ret, pc_inc, err_clr,
    output pc_out, sp_level, stack_full, stack_empty, stack_ovf, stack_unf
  );
endinterface

// File: rtl/program_counter_ras.sv
// Program counter with increment/load/branch and a call/return address stack.
// Optional macro PC_TRAP_EN: stack over/underflow redirects pc_out to TRAP_VEC.
module program_counter_ras #(
  parameter int unsigned  N        = 32,
  parameter int unsigned  DEPTH    = 8,
  parameter int unsigned  STEP     = 1,
  parameter logic [N-1:0] RST_VEC  = '0,
  parameter logic [N-1:0] TRAP_VEC = N'(32'hFFFF_FFF0)
) (
  input logic                 clk,
  input logic                 rst_n,
  program_counter_ras_if.slave bus
);
  localparam int unsigned  SPW    = $clog2(DEPTH + 1);
  localparam int unsigned  IW     = $clog2(DEPTH);
  localparam logic [N-1:0] STEP_N = N'(STEP);
`ifdef PC_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_STALL,
    CMD_LOAD,
    CMD_CALL,
    CMD_RET,
    CMD_BRANCH,
    CMD_INC
  } cmd_e;

  cmd_e           cmd;
  logic [N-1:0]   pc;
  logic [SPW-1:0] sp;
  logic           ovf;
  logic           unf;
  logic [N-1:0]   ras [DEPTH];
  logic           full;
  logic           empty;
  logic           ovf_set;
  logic           unf_set;
  logic [N-1:0]   err_pc;
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  pop_idx;

  always_comb begin
    cmd = CMD_HOLD;
    if (bus.pc_stall)       cmd = CMD_STALL;
    else if (bus.pc_load)   cmd = CMD_LOAD;
    else if (bus.pc_call)   cmd = CMD_CALL;
    else if (bus.pc_ret)    cmd = CMD_RET;
    else if (bus.pc_branch) cmd = CMD_BRANCH;
    else if (bus.pc_inc)    cmd = CMD_INC;
  end

  assign full     = (sp == SPW'(DEPTH));
  assign empty    = (sp == '0);
  assign ovf_set  = (cmd == CMD_CALL) && full;
  assign unf_set  = (cmd == CMD_RET) && empty;
  // Referencing TRAP_VEC in both builds keeps the parameter live; TRAP_EN folds away.
  assign err_pc   = TRAP_EN ? TRAP_VEC : pc;
  assign push_idx = IW'(sp);
  assign pop_idx  = IW'(sp - SPW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RST_VEC;
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) ras[i] <= '0;
    end else begin
      // A fresh error in the same cycle as err_clr leaves the flag set.
      ovf <= ovf_set | (ovf & ~bus.err_clr);
      unf <= unf_set | (unf & ~bus.err_clr);
      unique case (cmd)
        CMD_LOAD: pc <= bus.pc_data;
        CMD_CALL: begin
          if (full) begin
            pc <= err_pc;
          end else begin
            ras[push_idx] <= pc + STEP_N;
            sp            <= sp + SPW'(1);
            pc            <= bus.pc_data;
          end
        end
        CMD_RET: begin
          if (empty) begin
            pc <= err_pc;
          end else begin
            pc <= ras[pop_idx];
            sp <= sp - SPW'(1);
          end
        end
        CMD_BRANCH: pc <= pc + bus.pc_offset;
        CMD_INC:    pc <= pc + STEP_N;
        default:    ;
      endcase
    end
  end

  assign bus.pc_out      = pc;
  assign bus.sp_level    = sp;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_ovf   = ovf;
  assign bus.stack_unf   = unf;
endmodule

// File: tb/tb_program_counter_ras.sv
// Directed bench for program_counter_ras: queue-based reference model checked every cycle plus literal checkpoints.
module tb_program_counter_ras;
  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned STEP  = 1;
  localparam logic [31:0] TRAP  = 32'hFFFF_FFF0;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  program_counter_ras_if #(.N(N), .DEPTH(DEPTH)) bus ();

  program_counter_ras #(
    .N(N), .DEPTH(DEPTH), .STEP(STEP), .RST_VEC(32'h0), .TRAP_VEC(TRAP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: PC value, stack as a queue, two sticky flags.
  logic [31:0] m_pc  = 32'h0;
  logic [31:0] m_stk [$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      logic set_o, set_u;
      set_o = 1'b0;
      set_u = 1'b0;
      if (!bus.pc_stall) begin
        if (bus.pc_load) m_pc = bus.pc_data;
        else if (bus.pc_call) begin
          if (m_stk.size() == DEPTH) begin
            set_o = 1'b1;
`ifdef PC_TRAP_EN
            m_pc = TRAP;
`endif
          end else begin
            m_stk.push_back(m_pc + STEP);
            m_pc = bus.pc_data;
          end
        end else if (bus.pc_ret) begin
          if (m_stk.size() == 0) begin
            set_u = 1'b1;
`ifdef PC_TRAP_EN
            m_pc = TRAP;
`endif
          end else m_pc = m_stk.pop_back();
        end else if (bus.pc_branch) m_pc = m_pc + bus.pc_offset;
        else if (bus.pc_inc) m_pc = m_pc + STEP;
      end
      m_ovf = set_o | (m_ovf & ~bus.err_clr);
      m_unf = set_u | (m_unf & ~bus.err_clr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("pc_out", bus.pc_out, m_pc);
    check("sp_level", 32'(bus.sp_level), 32'(m_stk.size()));
    check("stack_full", 32'(bus.stack_full), 32'(m_stk.size() == DEPTH));
    check("stack_empty", 32'(bus.stack_empty), 32'(m_stk.size() == 0));
    check("stack_ovf", 32'(bus.stack_ovf), 32'(m_ovf));
    check("stack_unf", 32'(bus.stack_unf), 32'(m_unf));
  end

  task automatic idle_inputs();
    bus.pc_stall = 0; bus.pc_load = 0; bus.pc_call = 0; bus.pc_ret = 0;
    bus.pc_branch = 0; bus.pc_inc = 0; bus.err_clr = 0;
    bus.pc_data = '0; bus.pc_offset = '0;
  endtask

  // Drive one command at the falling edge, return just after the rising edge that samples it.
  task automatic step(input logic stall, input logic load, input logic call, input logic ret,
                      input logic br, input logic inc, input logic clr,
                      input logic [31:0] data, input logic [31:0] off);
    @(negedge clk);
    bus.pc_stall = stall; bus.pc_load = load; bus.pc_call = call; bus.pc_ret = ret;
    bus.pc_branch = br; bus.pc_inc = inc; bus.err_clr = clr;
    bus.pc_data = data; bus.pc_offset = off;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    logic [31:0] held;
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    check("reset pc", bus.pc_out, 32'h0);
    check("reset sp", 32'(bus.sp_level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 0, 0, 1, 0, 0, 0);
      check("inc seq", bus.pc_out, 32'(i));
    end

    step(0, 0, 1, 0, 0, 0, 0, 32'h80, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst pc", bus.pc_out, 32'h0);
    check("async rst sp", 32'(bus.sp_level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step(0, 1, 0, 0, 0, 0, 0, 32'h100, 0);
    check("load", bus.pc_out, 32'h100);
    step(0, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFF0);
    check("branch neg", bus.pc_out, 32'hF0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 32'h24);
    check("branch pos", bus.pc_out, 32'h114);
    step(0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("inc wrap", bus.pc_out, 32'h0);

    step(0, 1, 0, 0, 0, 0, 0, 32'h10, 0);
    step(0, 0, 1, 0, 0, 0, 0, 32'h200, 0);
    check("call1 pc", bus.pc_out, 32'h200);
    check("call1 sp", 32'(bus.sp_level), 32'd1);
    step(0, 0, 1, 0, 0, 0, 0, 32'h300, 0);
    check("call2 pc", bus.pc_out, 32'h300);
    check("call2 sp", 32'(bus.sp_level), 32'd2);
    step(0, 0, 0, 1, 1, 1, 0, 0, 32'h40);
    check("ret1 pc", bus.pc_out, 32'h201);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    check("ret2 pc", bus.pc_out, 32'h11);
    check("ret2 empty", 32'(bus.stack_empty), 32'd1);

    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 0, 0, 32'h1000 + 32'(i) * 32'h10, 0);
    check("fill full", 32'(bus.stack_full), 32'd1);
    held = bus.pc_out;
    check("fill pc", held, 32'h1070);
    step(0, 0, 1, 0, 0, 0, 0, 32'h5000, 0);
`ifdef PC_TRAP_EN
    check("ovf pc", bus.pc_out, TRAP);
`else
    check("ovf pc", bus.pc_out, 32'h1070);
`endif
    check("ovf flag", 32'(bus.stack_ovf), 32'd1);
    check("ovf sp", 32'(bus.sp_level), 32'd8);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    check("pop top", bus.pc_out, 32'h1061);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    check("drain pc", bus.pc_out, 32'h12);
    check("drain empty", 32'(bus.stack_empty), 32'd1);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    check("unf flag", 32'(bus.stack_unf), 32'd1);
    check("ovf sticky", 32'(bus.stack_ovf), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("clr ovf", 32'(bus.stack_ovf), 32'd0);
    check("clr unf", 32'(bus.stack_unf), 32'd0);

    step(0, 1, 0, 0, 0, 0, 0, 32'h20, 0);
    step(0, 0, 1, 0, 0, 0, 0, 32'h30, 0);
    step(0, 1, 1, 0, 0, 1, 0, 32'h40, 0);
    check("prio pc", bus.pc_out, 32'h40);
    check("prio sp", 32'(bus.sp_level), 32'd1);
    step(1, 0, 1, 0, 0, 1, 0, 32'h77, 0);
    check("stall pc", bus.pc_out, 32'h40);
    check("stall sp", 32'(bus.sp_level), 32'd1);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    check("ret after stall", bus.pc_out, 32'h21);
    step(0, 0, 0, 1, 0, 0, 1, 0, 0);
    check("clr+set unf", 32'(bus.stack_unf), 32'd1);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    check("stall clr", 32'(bus.stack_unf), 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
